sdram_arbit: RTL and testbench

- Command arbiter and pin mux between the SDRAM sub-controllers and the SDRAM device.
- Sequence of control: the initialization controller drives the pins until init_end; the arbiter then grants one of auto-refresh, write or read at a time.
- Routes the granted source's command, bank and address onto the device pins, and drives the write-data bus.
- Sits downstream of sdram_init, sdram_aref and the write/read modules; it is the sole driver of SDRAM command pins.

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_arbit.sv | 143 ++++++++++++++
 tb/tb_sdram_arbit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state type and bus width defaults.
// Pure declarations: no logic, no latency.
// No flow control here; users handle their own handshakes.
package sdram_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int BA_W_DEF   = 2;
    localparam int DQ_W_DEF   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MRS       = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// Command arbiter and pin mux: init owns the pins, then aref > write > read.
// Grants are registered (one cycle after request); pins are combinational from state.
// No preemption: a requester waits until the current service pulses its *_end.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_data,
    input  logic              wr_sdram_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_e state_q, state_d;
    logic aref_en_q, aref_en_d;
    logic wr_en_q, wr_en_d;
    logic rd_en_q, rd_en_d;
    logic cke_q, cke_d;
    logic [3:0] cmd_sel;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // init_end is only looked at in IDLE, so its later deassertion is harmless
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (aref_req)    state_d = ST_AREF;
                else if (wr_req) state_d = ST_WRITE;
                else if (rd_req) state_d = ST_READ;
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        aref_en_d = (state_d == ST_AREF);
        wr_en_d   = (state_d == ST_WRITE);
        rd_en_d   = (state_d == ST_READ);
        cke_d     = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            cke_q     <= 1'b0;
        end else begin
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            cke_q     <= cke_d;
        end
    end

    always_comb begin
        cmd_sel    = CMD_NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
        case (state_q)
            ST_IDLE: begin
                cmd_sel    = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd_sel    = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd_sel    = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd_sel    = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_sel    = CMD_NOP;
                sdram_ba   = '1;
                sdram_addr = '1;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
    assign aref_en      = aref_en_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign sdram_cke    = cke_q;
    assign sdram_dq_out = wr_data;
    // Only the write service may drive the shared DQ pads
    assign sdram_dq_oe  = wr_sdram_en && (state_q == ST_WRITE);

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: reset, refresh, priority, non-preemption, DQ gating, async reset.
// Inputs driven 1 time unit after the rising edge, outputs sampled 2 units after it.
module tb_sdram_arbit;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
    logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic [15:0] wr_data;
    logic        wr_sdram_en;
    logic        aref_en, wr_en, rd_en, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    int checks = 0;
    int failures = 0;

    logic [17:0] pins;
    logic [2:0]  grants;
    logic [17:0] p_init, p_aref, p_wr, p_rd, p_nop;

    assign pins   = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
    assign grants = {aref_en, wr_en, rd_en};

    always #5 sys_clk = ~sys_clk;

    sdram_arbit dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_sdram_en(wr_sdram_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #3;
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL reset_grants got=%b exp=000", grants); end
        checks++; if (sdram_cke !== 1'b0) begin failures++; $display("FAIL reset_cke got=%b exp=0", sdram_cke); end
        checks++; if (sdram_dq_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", sdram_dq_oe); end
        checks++; if (pins !== p_init) begin failures++; $display("FAIL reset_pins got=%h exp=%h", pins, p_init); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick(); settle();
        checks++; if (sdram_cke !== 1'b1) begin failures++; $display("FAIL preinit_cke got=%b exp=1", sdram_cke); end
        tick(); tick(); settle();
        checks++; if (pins !== p_init) begin failures++; $display("FAIL preinit_pins got=%h exp=%h", pins, p_init); end
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL preinit_grants got=%b exp=000", grants); end
    endtask

    task automatic test_refresh();
        init_end = 1'b1;
        tick();
        init_end = 1'b0;
        aref_req = 1'b1;
        settle();
        checks++; if (pins !== p_nop) begin failures++; $display("FAIL arbit_pins got=%h exp=%h", pins, p_nop); end
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL arbit_grants got=%b exp=000", grants); end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) begin aref_end = 1'b1; aref_req = 1'b0; end
            settle();
            checks++; if (grants !== 3'b100) begin failures++; $display("FAIL aref_hold%0d got=%b exp=100", k, grants); end
            checks++; if (pins !== p_aref) begin failures++; $display("FAIL aref_pins%0d got=%h exp=%h", k, pins, p_aref); end
        end
        tick();
        aref_end = 1'b0;
        settle();
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL aref_drop got=%b exp=000", grants); end
        checks++; if (pins !== p_nop) begin failures++; $display("FAIL aref_back_nop got=%h exp=%h", pins, p_nop); end
        tick(); settle();
        // init_end low now: must stay in ARBIT, not fall back to init pins
        checks++; if (pins !== p_nop) begin failures++; $display("FAIL init_end_ignored got=%h exp=%h", pins, p_nop); end
    endtask

    task automatic test_priority();
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick(); settle();
        checks++; if (grants !== 3'b100) begin failures++; $display("FAIL prio_first got=%b exp=100", grants); end
        aref_end = 1'b1; aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
        settle();
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL prio_gap1 got=%b exp=000", grants); end
        tick(); settle();
        checks++; if (grants !== 3'b010) begin failures++; $display("FAIL prio_second got=%b exp=010", grants); end
        checks++; if (pins !== p_wr) begin failures++; $display("FAIL prio_wr_pins got=%h exp=%h", pins, p_wr); end
        wr_end = 1'b1; wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
        settle();
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL prio_gap2 got=%b exp=000", grants); end
        tick(); settle();
        checks++; if (grants !== 3'b001) begin failures++; $display("FAIL prio_third got=%b exp=001", grants); end
        checks++; if (pins !== p_rd) begin failures++; $display("FAIL prio_rd_pins got=%h exp=%h", pins, p_rd); end
        rd_end = 1'b1; rd_req = 1'b0;
        tick();
        rd_end = 1'b0;
        settle();
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL prio_done got=%b exp=000", grants); end
    endtask

    task automatic test_nonpreempt();
        wr_req = 1'b1;
        tick(); settle();
        checks++; if (grants !== 3'b010) begin failures++; $display("FAIL np_write got=%b exp=010", grants); end
        aref_req = 1'b1; rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        settle();
        checks++; if (grants !== 3'b010) begin failures++; $display("FAIL np_hold got=%b exp=010", grants); end
        checks++; if (pins !== p_wr) begin failures++; $display("FAIL np_pins got=%h exp=%h", pins, p_wr); end
        wr_end = 1'b1; wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
        settle();
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL np_gap got=%b exp=000", grants); end
        tick(); settle();
        checks++; if (grants !== 3'b100) begin failures++; $display("FAIL np_aref_next got=%b exp=100", grants); end
        aref_end = 1'b1; aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
    endtask

    task automatic test_dq();
        rd_req = 1'b1;
        tick();
        wr_sdram_en = 1'b1; wr_data = 16'hA5A5;
        settle();
        checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL dq_in_read got=%b exp=1", rd_en); end
        checks++; if (sdram_dq_oe !== 1'b0) begin failures++; $display("FAIL dq_oe_read got=%b exp=0", sdram_dq_oe); end
        rd_end = 1'b1; rd_req = 1'b0;
        tick();
        rd_end = 1'b0; wr_req = 1'b1;
        settle();
        checks++; if (sdram_dq_oe !== 1'b0) begin failures++; $display("FAIL dq_oe_arbit got=%b exp=0", sdram_dq_oe); end
        tick(); settle();
        checks++; if (sdram_dq_oe !== 1'b1) begin failures++; $display("FAIL dq_oe_write got=%b exp=1", sdram_dq_oe); end
        checks++; if (sdram_dq_out !== 16'hA5A5) begin failures++; $display("FAIL dq_out got=%h exp=a5a5", sdram_dq_out); end
        wr_sdram_en = 1'b0;
        settle();
        checks++; if (sdram_dq_oe !== 1'b0) begin failures++; $display("FAIL dq_oe_en_low got=%b exp=0", sdram_dq_oe); end
        wr_end = 1'b1; wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
    endtask

    task automatic test_async_reset();
        rd_req = 1'b1;
        tick(); settle();
        checks++; if (grants !== 3'b001) begin failures++; $display("FAIL ar_read got=%b exp=001", grants); end
        #1;
        sys_rst_n = 1'b0;
        #1;
        checks++; if (grants !== 3'b000) begin failures++; $display("FAIL ar_grants got=%b exp=000", grants); end
        checks++; if (sdram_cke !== 1'b0) begin failures++; $display("FAIL ar_cke got=%b exp=0", sdram_cke); end
        checks++; if (pins !== p_init) begin failures++; $display("FAIL ar_pins got=%h exp=%h", pins, p_init); end
        rd_req = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick(); settle();
        checks++; if (pins !== p_init) begin failures++; $display("FAIL ar_idle_hold got=%h exp=%h", pins, p_init); end
        init_end = 1'b1;
        tick();
        wr_req = 1'b1;
        settle();
        checks++; if (pins !== p_nop) begin failures++; $display("FAIL ar_arbit got=%h exp=%h", pins, p_nop); end
        tick(); settle();
        checks++; if (grants !== 3'b010) begin failures++; $display("FAIL ar_resume got=%b exp=010", grants); end
        wr_req = 1'b0;
    endtask

    initial begin
        init_cmd = 4'b0010; init_ba = 2'd0; init_addr = 12'h400;
        aref_cmd = 4'b0001; aref_ba = 2'd1; aref_addr = 12'h011;
        wr_cmd   = 4'b0100; wr_ba   = 2'd2; wr_addr   = 12'h022;
        rd_cmd   = 4'b0101; rd_ba   = 2'd3; rd_addr   = 12'h033;
        init_end = 1'b0; aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
        wr_data = 16'h0000; wr_sdram_en = 1'b0;
        p_init = {4'b0010, 2'd0, 12'h400};
        p_aref = {4'b0001, 2'd1, 12'h011};
        p_wr   = {4'b0100, 2'd2, 12'h022};
        p_rd   = {4'b0101, 2'd3, 12'h033};
        p_nop  = {4'b0111, 2'b11, 12'hfff};

        test_reset();
        test_refresh();
        test_priority();
        test_nonpreempt();
        test_dq();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
